// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        UPD  = 2'd3
    } state_t;

endpackage

// File: rtl/fetch_ctrl_offset_mag.sv
// Splits a signed branch displacement into a direction (add/sub) and an
// unsigned magnitude; -0x8000 maps to sub with magnitude 0x8000.
module offset_mag
    import fetch_pkg::*;
(
    input  logic [WORD_W-1:0] branch_off,
    output logic              is_sub,
    output logic [WORD_W-1:0] mag
);

    logic [WORD_W-1:0] neg;

    assign is_sub = branch_off[WORD_W-1];
    assign neg    = (~branch_off) + {{(WORD_W-1){1'b0}}, 1'b1};
    assign mag    = is_sub ? neg : branch_off;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: reads one word per pc, holds it for decode,
// then issues a single PC-update strobe (inc/add/sub) for one cycle.
//
// state | meaning
// IDLE  | parked, no request; leaves when run=1
// REQ   | mem_req high with mem_addr=pc until mem_ack
// HOLD  | ir_valid high until decode asserts ir_ready
// UPD   | one-cycle PC-update strobe, then REQ or IDLE per run
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [WORD_W-1:0] pc,
    output logic              mem_req,
    output logic [WORD_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              branch_en,
    input  logic [WORD_W-1:0] branch_off,
    output logic              inc,
    output logic              add,
    output logic              sub,
    output logic [WORD_W-1:0] offset,
    output logic [WORD_W-1:0] fetch_count
);

    state_t            state;
    state_t            state_nxt;
    logic              fetch_done;
    logic              accept;
    logic              is_sub;
    logic [WORD_W-1:0] mag;

    offset_mag u_offset_mag (
        .branch_off (branch_off),
        .is_sub     (is_sub),
        .mag        (mag)
    );

    assign fetch_done = (state == REQ) && mem_ack;
    assign accept     = (state == HOLD) && ir_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = REQ;
            REQ:     if (mem_ack) state_nxt = HOLD;
            HOLD:    if (ir_ready) state_nxt = UPD;
            UPD:     state_nxt = run ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_addr = '0;
        ir_valid = 1'b0;
        case (state)
            REQ: begin
                mem_req  = 1'b1;
                mem_addr = pc;
            end
            HOLD:    ir_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir <= '0;
        end else if (fetch_done) begin
            ir <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count <= '0;
        end else if (accept) begin
            fetch_count <= fetch_count + {{(WORD_W-1){1'b0}}, 1'b1};
        end
    end

    // Strobes are captured at acceptance so they are high only during UPD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inc    <= 1'b0;
            add    <= 1'b0;
            sub    <= 1'b0;
            offset <= '0;
        end else begin
            inc    <= accept && !branch_en;
            add    <= accept && branch_en && !is_sub;
            sub    <= accept && branch_en && is_sub;
            offset <= (accept && branch_en) ? mag : '0;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed corner cases followed by a
// randomized memory/decode environment checked against a reference model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_ready;
    logic        branch_en;
    logic [15:0] branch_off;
    logic        inc;
    logic        add;
    logic        sub;
    logic [15:0] offset;
    logic [15:0] fetch_count;

    fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .pc          (pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .branch_en   (branch_en),
        .branch_off  (branch_off),
        .inc         (inc),
        .add         (add),
        .sub         (sub),
        .offset      (offset),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;   // 0 inc, 1 add, 2 sub
        logic [15:0] off;
        logic [15:0] cnt;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sq[$];
    logic [15:0] iq[$];
    logic [15:0] model_cnt = 16'h0;
    logic [15:0] last_ir   = 16'h0;
    bit          prev_valid = 1'b0;
    int          wait_left = 0;
    int          ns;
    exp_t        e_mon;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h expected nothing pending", name, act);
    endtask

    // Reference: plain decode of the branch rule, signed arithmetic on the displacement.
    function automatic exp_t model(input bit ben, input logic [15:0] boff, input logic [15:0] cnt);
        exp_t r;
        int   sv;
        sv    = int'($signed(boff));
        r.cnt = cnt;
        if (!ben) begin
            r.kind = 2'd0;
            r.off  = 16'h0;
        end else if (sv >= 0) begin
            r.kind = 2'd1;
            r.off  = boff;
        end else begin
            r.kind = 2'd2;
            r.off  = 16'(-sv);
        end
        return r;
    endfunction

    function automatic logic [2:0] kind_bits(input logic [1:0] k);
        case (k)
            2'd0:    return 3'b100;
            2'd1:    return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    task automatic accept_push(input bit ben, input logic [15:0] boff);
        model_cnt = model_cnt + 16'h1;
        sq.push_back(model(ben, boff, model_cnt));
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {27'h0, mem_req, ir_valid, inc, add, sub}, 32'h0);
        check({name, "_addr"}, {16'h0, mem_addr}, 32'h0);
        check({name, "_ir"}, {16'h0, ir}, 32'h0);
        check({name, "_offset"}, {16'h0, offset}, 32'h0);
        check({name, "_count"}, {16'h0, fetch_count}, 32'h0);
    endtask

    // Monitor: pops expectations whenever the DUT presents an ir or a strobe.
    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 1'b0;
        end else begin
            ns = int'(inc) + int'(add) + int'(sub);
            if (ns > 1) check("one_hot_strobe", ns, 1);
            if (ns != 0) begin
                check("strobe_outside_hold", {31'h0, ir_valid}, 32'h0);
                if (sq.size() == 0) begin
                    fail_now("unexpected_strobe", {29'h0, inc, add, sub});
                end else begin
                    e_mon = sq.pop_front();
                    check("strobe_kind", {29'h0, inc, add, sub}, {29'h0, kind_bits(e_mon.kind)});
                    check("offset", {16'h0, offset}, {16'h0, e_mon.off});
                    check("fetch_count", {16'h0, fetch_count}, {16'h0, e_mon.cnt});
                end
            end else begin
                check("offset_no_strobe", {16'h0, offset}, 32'h0);
            end
            if (ir_valid && !prev_valid) begin
                if (iq.size() == 0) fail_now("unexpected_ir_valid", {16'h0, ir});
                else last_ir = iq.pop_front();
            end
            check("ir", {16'h0, ir}, {16'h0, last_ir});
            check("mem_addr", {16'h0, mem_addr}, mem_req ? {16'h0, pc} : 32'h0);
            prev_valid = ir_valid;
        end
    end

    task automatic do_fetch(input logic [15:0] rdata, input int wt, input int hold,
                            input bit ben, input logic [15:0] boff, input bit run_in_hold);
        int k = 0;
        mem_ack  = 1'b0;
        ir_ready = 1'b0;
        while (!mem_req && k < 20) begin
            step();
            k++;
        end
        if (!mem_req) begin
            fail_now("timeout_mem_req", 32'h0);
            return;
        end
        for (int i = 0; i < wt; i++) step();
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        iq.push_back(rdata);
        step();
        mem_ack   = 1'b0;
        mem_rdata = 16'h0;
        check("hold_entry_valid", {31'h0, ir_valid}, 32'h1);
        run = run_in_hold;
        for (int i = 0; i < hold; i++) begin
            branch_en  = 1'b1;
            branch_off = 16'(i * 7);
            step();
            check("hold_valid", {31'h0, ir_valid}, 32'h1);
            check("hold_ir", {16'h0, ir}, {16'h0, rdata});
            check("hold_no_strobe", {29'h0, inc, add, sub}, 32'h0);
        end
        ir_ready   = 1'b1;
        branch_en  = ben;
        branch_off = boff;
        accept_push(ben, boff);
        step();
        ir_ready   = 1'b0;
        branch_en  = 1'b0;
        branch_off = 16'h0;
    endtask

    task automatic drive_cycle(input bit drain);
        mem_ack    = 1'b0;
        ir_ready   = 1'b0;
        mem_rdata  = 16'($urandom);
        branch_en  = 1'($urandom);
        branch_off = 16'($urandom);
        if (mem_req) begin
            if (drain || wait_left == 0) begin
                mem_ack = 1'b1;
                iq.push_back(mem_rdata);
                wait_left = int'($urandom_range(0, 3));
            end else begin
                wait_left--;
            end
        end else begin
            pc = 16'($urandom);
            mem_ack = ($urandom_range(0, 3) == 0);
        end
        if (ir_valid) begin
            if (drain || $urandom_range(0, 1) == 1) begin
                ir_ready = 1'b1;
                case ($urandom_range(0, 5))
                    0:       branch_off = 16'h0000;
                    1:       branch_off = 16'h8000;
                    2:       branch_off = 16'h7FFF;
                    3:       branch_off = 16'hFFFF;
                    default: ;
                endcase
                accept_push(branch_en, branch_off);
            end
        end else begin
            ir_ready = ($urandom_range(0, 3) == 0);
        end
        run = drain ? 1'b0 : ($urandom_range(0, 7) != 0);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; pc = 16'h0; mem_ack = 1'b0; mem_rdata = 16'h0;
        ir_ready = 1'b0; branch_en = 1'b0; branch_off = 16'h0;
        #2 reset = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) step();
        reset = 1'b1;
        step();
        check("idle_no_req", {31'h0, mem_req}, 32'h0);

        // First fetch with three wait states, plain increment.
        pc  = 16'h0010;
        run = 1'b1;
        step();
        check("first_req", {31'h0, mem_req}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            check("addr_stable", {16'h0, mem_addr}, 32'h0010);
            if (i == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'hABCD;
                iq.push_back(16'hABCD);
            end
            step();
        end
        mem_ack = 1'b0;
        check("ir_captured", {16'h0, ir}, 32'hABCD);
        ir_ready  = 1'b1;
        branch_en = 1'b0;
        accept_push(1'b0, 16'h0);
        step();
        ir_ready = 1'b0;
        check("inc_strobe", {29'h0, inc, add, sub}, 32'h4);
        check("count_one", {16'h0, fetch_count}, 32'h1);
        step();
        check("back_to_req", {31'h0, mem_req}, 32'h1);

        // Branch displacement corners and a long decode stall.
        do_fetch(16'h1111, 0, 0, 1'b1, 16'h0005, 1'b1);
        do_fetch(16'h2222, 2, 0, 1'b1, 16'hFFFB, 1'b1);
        do_fetch(16'h3333, 1, 0, 1'b1, 16'h8000, 1'b1);
        do_fetch(16'h4444, 0, 0, 1'b1, 16'h0000, 1'b1);
        do_fetch(16'h5555, 0, 10, 1'b0, 16'h0000, 1'b1);

        // run dropped during HOLD: UPD still happens, then park.
        do_fetch(16'h6666, 0, 2, 1'b1, 16'h0003, 1'b0);
        check("upd_after_run_low", {29'h0, inc, add, sub}, 32'h2);
        for (int i = 0; i < 3; i++) begin
            step();
            check("parked_idle", {31'h0, mem_req}, 32'h0);
        end

        // Counter wrap from 0xFFFF.
        force dut.fetch_count = 16'hFFFF;
        #1 release dut.fetch_count;
        model_cnt = 16'hFFFF;
        run = 1'b1;
        do_fetch(16'h7777, 0, 0, 1'b0, 16'h0000, 1'b1);
        check("count_wrap", {16'h0, fetch_count}, 32'h0);

        // Reset in the middle of a request, late ack after release.
        begin
            int k = 0;
            while (!mem_req && k < 20) begin
                step();
                k++;
            end
        end
        check("req_before_reset", {31'h0, mem_req}, 32'h1);
        #2 reset = 1'b0;
        #1 check_all_zero("mid_req_reset");
        sq.delete();
        iq.delete();
        last_ir   = 16'h0;
        model_cnt = 16'h0;
        run       = 1'b0;
        step();
        step();
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        pc        = 16'h0042;
        run       = 1'b1;
        reset     = 1'b1;
        step();
        mem_ack = 1'b0;
        check("req_after_release", {31'h0, mem_req}, 32'h1);
        check("addr_after_release", {16'h0, mem_addr}, 32'h0042);
        check("late_ack_ignored", {16'h0, ir}, 32'h0);
        do_fetch(16'h8888, 1, 0, 1'b1, 16'hFFF0, 1'b1);

        // Randomized traffic, then drain with run low.
        repeat (3000) begin
            drive_cycle(1'b0);
            step();
        end
        repeat (30) begin
            drive_cycle(1'b1);
            step();
        end
        mem_ack = 1'b0; ir_ready = 1'b0; run = 1'b0;
        repeat (3) step();
        check("strobe_queue_drained", sq.size(), 0);
        check("ir_queue_drained", iq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 run  in  1  fetch enable; 0 parks the block in IDLE after the current update.
REQ-004 pc  in  16  current program counter value from the PC register.
REQ-005 mem_req  out  1  instruction memory read request.
REQ-006 mem_addr  out  16  read address, equal to pc while mem_req=1, else 0.
REQ-007 mem_ack  in  1  memory completion; mem_rdata valid in same cycle.
REQ-008 mem_rdata  in  16  instruction word.
REQ-009 ir  out  16  instruction register.
REQ-010 ir_valid  out  1  ir holds an instruction not yet accepted by decode.
REQ-011 ir_ready  in  1  decode accepts ir this cycle.
REQ-012 branch_en  in  1  accepted instruction is a taken branch; qualified by ir_valid&ir_ready.
REQ-013 branch_off  in  16  signed two's-complement branch displacement; qualified as branch_en.
REQ-014 inc / add / sub  out  1 each  PC control strobes, at most one high in any cycle.
REQ-015 offset  out  16  unsigned magnitude for add/sub; 0 when no strobe high.
REQ-016 fetch_count  out  16  number of instructions accepted by decode.

Function
REQ-017 The state machine SHALL have states IDLE, REQ, HOLD, UPD.
REQ-018 IDLE: all strobes low, mem_req=0; run=1 -> REQ next cycle.
REQ-019 REQ: mem_req=1, mem_addr=pc, both held stable until mem_ack=1; on mem_ack, ir<=mem_rdata, -> HOLD.
REQ-020 mem_ack in the same cycle mem_req first rises SHALL complete the fetch (1-cycle minimum REQ).
REQ-021 mem_ack outside REQ SHALL be ignored; ir SHALL not change.
REQ-022 HOLD: ir_valid=1, ir stable; on ir_ready=1 -> UPD, fetch_count increments (wraps 0xFFFF -> 0x0000).
REQ-023 On acceptance with branch_en=0, UPD SHALL drive inc=1, offset=0.
REQ-024 On acceptance with branch_en=1 and branch_off[15]=0, UPD SHALL drive add=1, offset=branch_off.
REQ-025 On acceptance with branch_en=1 and branch_off[15]=1, UPD SHALL drive sub=1, offset=(-branch_off) mod 2^16; 0x8000 yields sub=1, offset=0x8000.
REQ-026 branch_en=1 with branch_off=0 SHALL drive add=1, offset=0 (refetch same address).
REQ-027 branch_en/branch_off outside an accepting cycle SHALL be ignored.
REQ-028 UPD SHALL last exactly one cycle, then -> REQ if run=1, else IDLE.
REQ-029 run deasserted in REQ or HOLD SHALL not abort the transaction; it is sampled only in UPD and IDLE.
REQ-030 ir_valid SHALL be 1 only in HOLD; strobes only in UPD.
REQ-031 Steady-state throughput with mem_ack and ir_ready tied high SHALL be one instruction per 3 cycles (REQ, HOLD, UPD).

Reset
REQ-032 reset=0 SHALL immediately force state=IDLE, mem_req=0, mem_addr=0, ir=0, ir_valid=0, inc=add=sub=0, offset=0, fetch_count=0, regardless of clk.
REQ-033 Reset mid-REQ SHALL drop mem_req without waiting for mem_ack; a late mem_ack after release SHALL be ignored.
REQ-034 After reset release the first fetch SHALL start in the cycle after run is seen high in IDLE.

Structure
REQ-035 A shared package fetch_pkg SHALL hold the state encoding (IDLE, REQ, HOLD, UPD) and the constant WORD_W=16.
REQ-036 One sub-module, offset_mag (combinational: branch_off -> add/sub select and 16-bit magnitude), SHALL be instantiated; all other logic lives in fetch_ctrl.
REQ-037 ir, captured strobe selection, and offset magnitude SHALL be registered; strobes SHALL not be combinational from inputs.

Verification
REQ-038 reset=0 mid-REQ, then release with run=1 -> all outputs 0 immediately, mem_req rises one cycle after IDLE, mem_addr=pc.
REQ-039 pc=0x0010, mem_ack after 3 wait cycles with rdata=0xABCD, ir_ready=1, branch_en=0 -> ir=0xABCD, mem_addr stable 4 cycles, inc=1 one cycle, fetch_count=1.
REQ-040 Accept with branch_en=1, branch_off=0x0005 -> add=1, offset=0x0005; branch_off=0xFFFB -> sub=1, offset=0x0005.
REQ-041 branch_off=0x8000 -> sub=1, offset=0x8000; branch_off=0x0000 -> add=1, offset=0x0000.
REQ-042 ir_ready held 0 for 10 cycles in HOLD -> ir_valid=1 and ir constant throughout; no strobe until acceptance.
REQ-043 fetch_count preloaded to 0xFFFF via 65535 fetches (or forced) -> next accept gives 0x0000; run=0 during HOLD -> completes UPD then enters IDLE.
